// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the attached uarttx.
// The slave modport is the arbiter side; master is the environment driving requests.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic [GW-1:0]        grant_id;
  logic                 xfer_done;
  logic                 timeout_err;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_send, tx_data, busy, grant_id, xfer_done, timeout_err
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_send, tx_data, busy, grant_id, xfer_done, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uarttx between NUM_REQ byte producers,
// holding send long enough for the slow transmitter and guarding WAIT with a watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SEND_HOLD = 104,
  parameter int TIMEOUT   = 4096
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW   = $clog2(NUM_REQ);
  localparam int MAXC = (SEND_HOLD > TIMEOUT) ? SEND_HOLD : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 done_q;
  logic [GW-1:0]        last_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic                 tx_send_q;
  logic [7:0]           tx_data_q;
  logic [GW-1:0]        grant_q;
  logic                 xfer_done_q;
  logic                 timeout_q;

  logic                 done_rise;
  logic [7:0]           req_bytes [NUM_REQ];
  logic [GW-1:0]        cand_idx  [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_hit;
  logic                 sel_found;
  logic [GW-1:0]        sel_idx;

  assign done_rise = bus.tx_done & ~done_q;

  // Candidate gi is the requester (gi+1) places after the last grant, wrapped.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [GW:0] sum_w;
    assign req_bytes[gi] = bus.req_data[8*gi +: 8];
    assign sum_w         = {1'b0, last_q} + (GW+1)'(gi + 1);
    assign cand_idx[gi]  = (sum_w >= (GW+1)'(NUM_REQ)) ? GW'(sum_w - (GW+1)'(NUM_REQ))
                                                       : sum_w[GW-1:0];
    assign cand_hit[gi]  = bus.req_valid[cand_idx[gi]];
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      last_q      <= GW'(NUM_REQ - 1);
      req_ready_q <= '0;
      tx_send_q   <= 1'b0;
      tx_data_q   <= '0;
      grant_q     <= '0;
      xfer_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q      <= bus.tx_done;
      req_ready_q <= '0;
      xfer_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            req_ready_q <= NUM_REQ'(1) << sel_idx;
            tx_data_q   <= req_bytes[sel_idx];
            tx_send_q   <= 1'b1;
            grant_q     <= sel_idx;
            last_q      <= sel_idx;
            cnt_q       <= '0;
            state_q     <= ST_SEND;
          end else begin
            tx_send_q   <= 1'b0;
          end
        end
        ST_SEND: begin
          // A done edge here belongs to no byte of ours and is dropped.
          if (cnt_q == CW'(SEND_HOLD - 1)) begin
            tx_send_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_WAIT;
          end else begin
            cnt_q     <= cnt_q + CW'(1);
          end
        end
        ST_WAIT: begin
          if (done_rise) begin
            xfer_done_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            timeout_q   <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q       <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          tx_send_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_send     = tx_send_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.xfer_done   = xfer_done_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, send hold, done/timeout paths and reset.
module tb_uart_tx_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   c, g, n, stray, nx, exp_id, eb;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ  (4),
    .SEND_HOLD(104),
    .TIMEOUT  (4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    repeat (3) tick;

    check("rst_ready",   32'(bus.req_ready),   32'h0);
    check("rst_send",    32'(bus.tx_send),     32'h0);
    check("rst_data",    32'(bus.tx_data),     32'h0);
    check("rst_busy",    32'(bus.busy),        32'h0);
    check("rst_grant",   32'(bus.grant_id),    32'h0);
    check("rst_xfer",    32'(bus.xfer_done),   32'h0);
    check("rst_timeout", 32'(bus.timeout_err), 32'h0);
    rst = 1'b0;

    // single byte from requester 0
    bus.req_data  = 32'h0000_00A5;
    bus.req_valid = 4'b0001;
    tick;
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    check("t1_send",  32'(bus.tx_send),   32'h1);
    check("t1_data",  32'(bus.tx_data),   32'hA5);
    check("t1_busy",  32'(bus.busy),      32'h1);
    check("t1_grant", 32'(bus.grant_id),  32'h0);
    bus.req_valid = '0;
    tick;
    check("t1_ready_pulse", 32'(bus.req_ready), 32'h0);
    n = 2;
    g = 0;
    while (bus.tx_send && g < 300) begin
      tick;
      g++;
      if (bus.tx_send) n++;
    end
    check("t1_send_len", 32'(n), 32'd104);
    repeat (20) tick;
    check("t1_wait_busy", 32'(bus.busy), 32'h1);
    bus.tx_done = 1'b1;
    tick;
    check("t1_xfer",      32'(bus.xfer_done),   32'h1);
    check("t1_busy_fall", 32'(bus.busy),        32'h0);
    check("t1_grant_end", 32'(bus.grant_id),    32'h0);
    check("t1_no_to",     32'(bus.timeout_err), 32'h0);
    tick;
    check("t1_xfer_pulse", 32'(bus.xfer_done), 32'h0);
    bus.tx_done = 1'b0;

    // round robin with all four requesters valid
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.req_data  = 32'h4433_2211;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      eb     = 17 * (exp_id + 1);
      g = 0;
      while (bus.req_ready == '0 && g < 10) begin
        tick;
        g++;
      end
      check("rr_ready", 32'(bus.req_ready), 32'(1 << exp_id));
      check("rr_grant", 32'(bus.grant_id),  32'(exp_id));
      check("rr_data",  32'(bus.tx_data),   32'(eb));
      stray = 0;
      g = 0;
      tick;
      while (bus.tx_send && g < 300) begin
        if (bus.req_ready != '0) stray++;
        tick;
        g++;
      end
      repeat (49) begin
        if (bus.req_ready != '0) stray++;
        tick;
      end
      bus.tx_done = 1'b1;
      tick;
      check("rr_xfer",  32'(bus.xfer_done), 32'h1);
      check("rr_stray", 32'(stray),         32'h0);
      bus.tx_done = 1'b0;
      if (k == 4) bus.req_valid = '0;
    end

    // watchdog timeout, then the waiting requester 3 goes next
    bus.req_data  = 32'h7E5C_0000;
    bus.req_valid = 4'b0100;
    tick;
    check("to_ready", 32'(bus.req_ready), 32'h4);
    check("to_grant", 32'(bus.grant_id),  32'h2);
    check("to_data",  32'(bus.tx_data),   32'h5C);
    bus.req_valid = 4'b1000;
    c = 0;
    while (!bus.timeout_err && c < 5000) begin
      tick;
      c++;
    end
    check("to_latency", 32'(c),             32'd4200);
    check("to_busy",    32'(bus.busy),      32'h0);
    check("to_no_xfer", 32'(bus.xfer_done), 32'h0);
    tick;
    check("to_next_ready", 32'(bus.req_ready),   32'h8);
    check("to_next_grant", 32'(bus.grant_id),    32'h3);
    check("to_next_data",  32'(bus.tx_data),     32'h7E);
    check("to_pulse",      32'(bus.timeout_err), 32'h0);
    bus.req_valid = '0;

    // reset in the middle of SEND
    repeat (29) tick;
    check("mr_send_pre", 32'(bus.tx_send), 32'h1);
    rst = 1'b1;
    bus.req_data  = 32'h0099_0066;
    bus.req_valid = 4'b0101;
    tick;
    check("mr_send",    32'(bus.tx_send),     32'h0);
    check("mr_busy",    32'(bus.busy),        32'h0);
    check("mr_data",    32'(bus.tx_data),     32'h0);
    check("mr_grant",   32'(bus.grant_id),    32'h0);
    check("mr_ready",   32'(bus.req_ready),   32'h0);
    check("mr_xfer",    32'(bus.xfer_done),   32'h0);
    check("mr_timeout", 32'(bus.timeout_err), 32'h0);
    rst = 1'b0;
    tick;
    check("mr_prio_ready", 32'(bus.req_ready), 32'h1);
    check("mr_prio_grant", 32'(bus.grant_id),  32'h0);
    check("mr_prio_data",  32'(bus.tx_data),   32'h66);

    // done edge during SEND, held high: must time out
    bus.req_valid = '0;
    c = 0;
    repeat (10) begin
      tick;
      c++;
    end
    bus.tx_done = 1'b1;
    nx = 0;
    while (!bus.timeout_err && c < 5000) begin
      tick;
      c++;
      if (bus.xfer_done) nx++;
    end
    check("sr_no_xfer", 32'(nx),              32'h0);
    check("sr_timeout", 32'(bus.timeout_err), 32'h1);
    check("sr_latency", 32'(c),               32'd4200);
    bus.tx_done = 1'b0;

    // done edge on the timeout terminal cycle: done wins
    bus.req_data  = 32'h0000_3C00;
    bus.req_valid = 4'b0010;
    tick;
    check("tc_grant", 32'(bus.grant_id), 32'h1);
    check("tc_data",  32'(bus.tx_data),  32'h3C);
    bus.req_valid = '0;
    repeat (4199) tick;
    check("tc_pre_to", 32'(bus.timeout_err), 32'h0);
    bus.tx_done = 1'b1;
    tick;
    check("tc_xfer",    32'(bus.xfer_done),   32'h1);
    check("tc_no_to",   32'(bus.timeout_err), 32'h0);
    check("tc_busy",    32'(bus.busy),        32'h0);
    tick;
    check("tc_late_to", 32'(bus.timeout_err), 32'h0);
    bus.tx_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
